if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline. It sits directly upstream of the ID stage.
- Holds the PC and fetches from instruction memory over a req/ready handshake.
- Presents `{pc+4, instruction}` to ID on its `pc`/`inst` inputs.
- Accepts the branch/jump redirect that ID resolves (`pcmultiplexed`).
- Honours stalls from the hazard unit.

---
 rtl/if_stage.sv | 143 ++++++++++++++
 tb/tb_if_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for a 5-stage MIPS pipeline.
// Fetches over a req/ready handshake, buffers one word under stall, and drops stale fetches on redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        pc_sel,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        FETCH,
        BUF,
        DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_d;
    logic        req_d;
    logic [31:0] inst_d, pc_out_d;
    logic        valid_d;
    logic [31:0] buf_q, buf_d;

    logic        transfer;
    logic [31:0] addr_inc;
    logic [31:0] target;

    assign transfer = imem_req & imem_ready;
    assign addr_inc = imem_addr + 32'd4;
    assign target   = {pc_target[31:2], 2'b00};

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = imem_addr;
        req_d    = imem_req;
        inst_d   = inst_out;
        pc_out_d = pc_out;
        valid_d  = valid_out;
        buf_d    = buf_q;

        case (state_q)
            FETCH: begin
                if (pc_sel) begin
                    pc_d    = target;
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    buf_d   = NOP_INST;
                    // A pending request must finish before its address may change.
                    if (imem_req && !imem_ready) begin
                        state_d = DROP;
                    end else begin
                        addr_d = target;
                        req_d  = 1'b1;
                    end
                end else if (transfer && !stall) begin
                    inst_d   = imem_rdata;
                    pc_out_d = addr_inc;
                    valid_d  = 1'b1;
                    pc_d     = addr_inc;
                    addr_d   = addr_inc;
                end else if (transfer) begin
                    buf_d   = imem_rdata;
                    req_d   = 1'b0;
                    state_d = BUF;
                end else begin
                    if (!stall) begin
                        inst_d  = NOP_INST;
                        valid_d = 1'b0;
                    end
                    if (!imem_req) req_d = 1'b1;
                end
            end

            BUF: begin
                if (pc_sel) begin
                    pc_d    = target;
                    addr_d  = target;
                    req_d   = 1'b1;
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    buf_d   = NOP_INST;
                    state_d = FETCH;
                end else if (!stall) begin
                    inst_d   = buf_q;
                    pc_out_d = addr_inc;
                    valid_d  = 1'b1;
                    pc_d     = addr_inc;
                    addr_d   = addr_inc;
                    req_d    = 1'b1;
                    state_d  = FETCH;
                end
            end

            DROP: begin
                if (pc_sel) begin
                    pc_d = target;
                end else if (imem_ready) begin
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
            end

            default: state_d = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            imem_addr <= RESET_PC;
            imem_req  <= 1'b0;
            inst_out  <= NOP_INST;
            pc_out    <= 32'h0000_0000;
            valid_out <= 1'b0;
            buf_q     <= NOP_INST;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            imem_addr <= addr_d;
            imem_req  <= req_d;
            inst_out  <= inst_d;
            pc_out    <= pc_out_d;
            valid_out <= valid_d;
            buf_q     <= buf_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table plus reset and wrap-around sequences.
// The memory model answers with rdata = addr ^ 32'hA5A5_0000.
module tb_if_stage;

    localparam logic [31:0] PAT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        pc_sel = 1'b0;
    logic [31:0] pc_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        valid_out;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_pc_out;
    logic [31:0] w_inst_out;
    logic        w_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ PAT;
    assign w_rdata    = w_addr ^ PAT;

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc_sel(pc_sel), .pc_target(pc_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .inst_out(inst_out), .valid_out(valid_out)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0000)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .pc_sel(1'b0), .pc_target(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1), .imem_rdata(w_rdata),
        .pc_out(w_pc_out), .inst_out(w_inst_out), .valid_out(w_valid)
    );

    typedef struct {
        logic        stall;
        logic        pc_sel;
        logic [31:0] target;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic s, logic p, logic [31:0] t, logic r,
                                logic q, logic [31:0] a, logic [31:0] i, logic [31:0] pc, logic v);
        vec_t x;
        x.stall = s; x.pc_sel = p; x.target = t; x.ready = r;
        x.req = q; x.addr = a; x.inst = i; x.pc = pc; x.valid = v;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic q, input logic [31:0] a,
                             input logic [31:0] i, input logic [31:0] pc, input logic v);
        check({tag, " req"},   {31'b0, imem_req},  {31'b0, q});
        check({tag, " addr"},  imem_addr,          a);
        check({tag, " inst"},  inst_out,           i);
        check({tag, " pc"},    pc_out,             pc);
        check({tag, " valid"}, {31'b0, valid_out}, {31'b0, v});
    endtask

    initial begin
        // stall, pc_sel, target, ready | req, addr, inst, pc_out, valid (after the edge)
        vecs[0]  = mk(0, 0, 32'h0,   1, 1, 32'h000, 32'h0,          32'h000, 0);
        vecs[1]  = mk(0, 0, 32'h0,   1, 1, 32'h004, PAT ^ 32'h000,  32'h004, 1);
        vecs[2]  = mk(0, 0, 32'h0,   1, 1, 32'h008, PAT ^ 32'h004,  32'h008, 1);
        vecs[3]  = mk(1, 0, 32'h0,   1, 0, 32'h008, PAT ^ 32'h004,  32'h008, 1);
        vecs[4]  = mk(1, 0, 32'h0,   1, 0, 32'h008, PAT ^ 32'h004,  32'h008, 1);
        vecs[5]  = mk(1, 0, 32'h0,   1, 0, 32'h008, PAT ^ 32'h004,  32'h008, 1);
        vecs[6]  = mk(0, 0, 32'h0,   1, 1, 32'h00C, PAT ^ 32'h008,  32'h00C, 1);
        vecs[7]  = mk(0, 0, 32'h0,   1, 1, 32'h010, PAT ^ 32'h00C,  32'h010, 1);
        vecs[8]  = mk(0, 0, 32'h0,   0, 1, 32'h010, 32'h0,          32'h010, 0);
        vecs[9]  = mk(0, 1, 32'h103, 0, 1, 32'h010, 32'h0,          32'h010, 0);
        vecs[10] = mk(0, 0, 32'h0,   1, 1, 32'h100, 32'h0,          32'h010, 0);
        vecs[11] = mk(0, 0, 32'h0,   1, 1, 32'h104, PAT ^ 32'h100,  32'h104, 1);
        vecs[12] = mk(1, 0, 32'h0,   1, 0, 32'h104, PAT ^ 32'h100,  32'h104, 1);
        vecs[13] = mk(1, 1, 32'h200, 0, 1, 32'h200, 32'h0,          32'h104, 0);
        vecs[14] = mk(0, 0, 32'h0,   1, 1, 32'h204, PAT ^ 32'h200,  32'h204, 1);
        vecs[15] = mk(0, 0, 32'h0,   1, 1, 32'h208, PAT ^ 32'h204,  32'h208, 1);
        vecs[16] = mk(0, 1, 32'h302, 1, 1, 32'h300, 32'h0,          32'h208, 0);
        vecs[17] = mk(0, 0, 32'h0,   1, 1, 32'h304, PAT ^ 32'h300,  32'h304, 1);
        vecs[18] = mk(1, 0, 32'h0,   0, 1, 32'h304, PAT ^ 32'h300,  32'h304, 1);
        vecs[19] = mk(0, 0, 32'h0,   1, 1, 32'h308, PAT ^ 32'h304,  32'h308, 1);

        #1;
        check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            stall      = vecs[i].stall;
            pc_sel     = vecs[i].pc_sel;
            pc_target  = vecs[i].target;
            imem_ready = vecs[i].ready;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].inst,
                      vecs[i].pc, vecs[i].valid);
            @(negedge clk);
        end

        // Reset asserted while a request waits: outputs clear without a clock edge.
        stall = 1'b0; pc_sel = 1'b0; imem_ready = 1'b0;
        @(posedge clk);
        #2;
        check("pre-reset req", {31'b0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async req", {31'b0, imem_req}, 32'd0);
        check("async valid", {31'b0, valid_out}, 32'd0);
        check("async addr", imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("restart req", {31'b0, imem_req}, 32'd1);
        check("restart addr", imem_addr, 32'h0);
        check("wrap addr0", w_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        check("restart inst", inst_out, PAT);
        check("restart pc", pc_out, 32'h4);
        check("wrap inst", w_inst_out, 32'hFFFF_FFFC ^ PAT);
        check("wrap pc", w_pc_out, 32'h0);
        check("wrap addr1", w_addr, 32'h0);
        check("wrap valid", {31'b0, w_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
